// File: rtl/cam_lru_table.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : cam_lru_table                                                |
// | Desc    : Fully associative key/value CAM with true-LRU replacement,   |
// |           hit-update writes, invalidate-by-key, eviction reporting and |
// |           a sequenced one-entry-per-cycle flush.                       |
// |           Optional: CAM_LRU_STATS_EN builds lookup hit/miss counters.  |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module cam_lru_table #(
  parameter int KEY_W = 16,
  parameter int VAL_W = 32,
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lkp_vld,
  input  logic [KEY_W-1:0] lkp_key,
  output logic             lkp_hit,
  output logic [IDX_W-1:0] lkp_idx,
  output logic [VAL_W-1:0] lkp_val,
  input  logic             wr_vld,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [VAL_W-1:0] wr_val,
  input  logic             inv_vld,
  input  logic [KEY_W-1:0] inv_key,
  input  logic             flush_req,
  output logic             busy,
  output logic             evict_vld,
  output logic [KEY_W-1:0] evict_key,
  output logic [VAL_W-1:0] evict_val,
  output logic [IDX_W:0]   count,
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_misses
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_FLUSH = 1'b1;
  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH-1);
  localparam logic [IDX_W-1:0] AGE_ONE  = IDX_W'(1);

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [DEPTH-1:0] r_valid, w_valid_nxt;
  logic [IDX_W-1:0] r_age [DEPTH];
  logic [IDX_W-1:0] w_age_nxt [DEPTH];
  logic [KEY_W-1:0] r_key [DEPTH];
  logic [VAL_W-1:0] r_val [DEPTH];

  logic             w_idle, w_full, w_evict, w_lkp_ok;
  logic             w_lkp_hit, w_wr_hit, w_inv_hit;
  logic [IDX_W-1:0] w_lkp_idx, w_wr_idx, w_inv_idx, w_free_idx, w_lru_idx;
  logic [IDX_W:0]   w_count;
  logic             w_store, w_touch;
  logic [IDX_W-1:0] w_tgt;
  logic [IDX_W:0]   w_touch_lim;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_full   = (w_count == FULL_CNT);
  assign w_lkp_ok = w_idle && lkp_vld && w_lkp_hit;
  assign w_evict  = w_idle && wr_vld && !w_wr_hit && w_full;
  assign busy     = (r_state == ST_FLUSH);
  assign count    = w_count;

  // Key match for all three ports, free/LRU slot search and population count
  always_comb begin
    w_lkp_hit = 1'b0; w_lkp_idx = '0;
    w_wr_hit  = 1'b0; w_wr_idx  = '0;
    w_inv_hit = 1'b0; w_inv_idx = '0;
    w_lru_idx = '0;   w_free_idx = '0;
    w_count   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && r_key[i] == lkp_key) begin w_lkp_hit = 1'b1; w_lkp_idx = IDX_W'(i); end
      if (r_valid[i] && r_key[i] == wr_key)  begin w_wr_hit  = 1'b1; w_wr_idx  = IDX_W'(i); end
      if (r_valid[i] && r_key[i] == inv_key) begin w_inv_hit = 1'b1; w_inv_idx = IDX_W'(i); end
      if (r_valid[i] && r_age[i] == LAST_IDX) w_lru_idx = IDX_W'(i);
      w_count = w_count + (IDX_W+1)'(r_valid[i]);
    end
    // Descending scan so the lowest invalid index wins
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  // Next valid/age state: flush clear, or write > invalidate > lookup-touch
  always_comb begin
    w_valid_nxt = r_valid;
    w_age_nxt   = r_age;
    w_store     = 1'b0;
    w_touch     = 1'b0;
    w_tgt       = '0;
    w_touch_lim = '0;
    if (r_state == ST_FLUSH) begin
      w_valid_nxt[r_ptr] = 1'b0;
      w_age_nxt[r_ptr]   = '0;
    end else if (wr_vld) begin
      w_store = 1'b1;
      w_touch = 1'b1;
      if (w_wr_hit) begin
        w_tgt = w_wr_idx;   w_touch_lim = {1'b0, r_age[w_wr_idx]};
      end else if (!w_full) begin
        // Limit above every legal age: all valid entries age by one
        w_tgt = w_free_idx; w_touch_lim = FULL_CNT;
      end else begin
        w_tgt = w_lru_idx;  w_touch_lim = {1'b0, LAST_IDX};
      end
    end else if (inv_vld) begin
      if (w_inv_hit) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (r_valid[j] && r_age[j] > r_age[w_inv_idx]) w_age_nxt[j] = r_age[j] - AGE_ONE;
        end
        w_valid_nxt[w_inv_idx] = 1'b0;
        w_age_nxt[w_inv_idx]   = '0;
      end
    end else if (lkp_vld && w_lkp_hit) begin
      w_touch = 1'b1;
      w_tgt = w_lkp_idx; w_touch_lim = {1'b0, r_age[w_lkp_idx]};
    end
    if (w_touch) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (r_valid[j] && {1'b0, r_age[j]} < w_touch_lim) w_age_nxt[j] = r_age[j] + AGE_ONE;
      end
      w_valid_nxt[w_tgt] = 1'b1;
      w_age_nxt[w_tgt]   = '0;
    end
  end

  // Control state, valid/age arrays and registered lookup/evict outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_valid   <= '0;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
      lkp_hit   <= 1'b0;
      lkp_idx   <= '0;
      lkp_val   <= '0;
      evict_vld <= 1'b0;
      evict_key <= '0;
      evict_val <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_age   <= w_age_nxt;
      if (r_state == ST_IDLE) begin
        if (flush_req) begin
          r_state <= ST_FLUSH;
          r_ptr   <= '0;
        end
      end else begin
        r_ptr <= r_ptr + AGE_ONE;
        if (r_ptr == LAST_IDX) r_state <= ST_IDLE;
      end
      lkp_hit   <= w_lkp_ok;
      lkp_idx   <= w_lkp_ok ? w_lkp_idx : '0;
      lkp_val   <= w_lkp_ok ? r_val[w_lkp_idx] : '0;
      evict_vld <= w_evict;
      evict_key <= w_evict ? r_key[w_lru_idx] : '0;
      evict_val <= w_evict ? r_val[w_lru_idx] : '0;
    end
  end

  // Key/value storage is qualified by the valid bits, so it carries no reset
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_key[w_tgt] <= wr_key;
      r_val[w_tgt] <= wr_val;
    end
  end

`ifdef CAM_LRU_STATS_EN
  logic [31:0] r_hits, r_misses;

  // Lookup statistics, cleared when a flush starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (w_idle && flush_req) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (w_idle && lkp_vld) begin
      if (w_lkp_hit) r_hits   <= r_hits + 32'd1;
      else           r_misses <= r_misses + 32'd1;
    end
  end

  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
`else
  assign stat_hits   = 32'h0;
  assign stat_misses = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cam_lru_table.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_cam_lru_table                                             |
// | Desc    : Directed self-checking bench for cam_lru_table (DEPTH=8).    |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_cam_lru_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        lkp_vld, wr_vld, inv_vld, flush_req;
  logic [15:0] lkp_key, wr_key, inv_key;
  logic [31:0] wr_val;
  logic        lkp_hit, busy, evict_vld;
  logic [2:0]  lkp_idx;
  logic [31:0] lkp_val, evict_val, stat_hits, stat_misses;
  logic [15:0] evict_key;
  logic [3:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  cam_lru_table dut (
    .clk(clk), .rst(rst),
    .lkp_vld(lkp_vld), .lkp_key(lkp_key),
    .lkp_hit(lkp_hit), .lkp_idx(lkp_idx), .lkp_val(lkp_val),
    .wr_vld(wr_vld), .wr_key(wr_key), .wr_val(wr_val),
    .inv_vld(inv_vld), .inv_key(inv_key),
    .flush_req(flush_req), .busy(busy),
    .evict_vld(evict_vld), .evict_key(evict_key), .evict_val(evict_val),
    .count(count), .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] k, input logic [31:0] v);
    wr_vld = 1'b1; wr_key = k; wr_val = v;
    step();
    wr_vld = 1'b0;
  endtask

  task automatic do_lookup(input logic [15:0] k);
    lkp_vld = 1'b1; lkp_key = k;
    step();
    lkp_vld = 1'b0;
  endtask

  task automatic do_inv(input logic [15:0] k);
    inv_vld = 1'b1; inv_key = k;
    step();
    inv_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    lkp_vld = 0; wr_vld = 0; inv_vld = 0; flush_req = 0;
    lkp_key = '0; wr_key = '0; inv_key = '0; wr_val = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_evict", evict_vld, 0);
    check("rst_lkp_hit", lkp_hit, 0);
    do_lookup(16'h1234);
    check("miss_hit", lkp_hit, 0);
    check("miss_idx", lkp_idx, 0);
    check("miss_val", lkp_val, 0);

    // Fill, touch idx 0, then a full-table write evicts idx 1
    for (int i = 0; i < 8; i++) begin
      do_write(16'h10 + 16'(i), 32'hA0 + 32'(i));
      check("fill_evict", evict_vld, 0);
    end
    check("fill_count", count, 8);
    do_lookup(16'h10);
    check("lk10_hit", lkp_hit, 1);
    check("lk10_idx", lkp_idx, 0);
    check("lk10_val", lkp_val, 32'hA0);
    do_write(16'h18, 32'hA8);
    check("ev_vld", evict_vld, 1);
    check("ev_key", evict_key, 16'h11);
    check("ev_val", evict_val, 32'hA1);
    check("ev_count", count, 8);
    do_lookup(16'h18);
    check("lk18_hit", lkp_hit, 1);
    check("lk18_idx", lkp_idx, 1);
    check("lk18_val", lkp_val, 32'hA8);
    check("ev_pulse", evict_vld, 0);

    // Write hit overwrites in place
    do_write(16'h15, 32'hFF);
    check("wh_evict", evict_vld, 0);
    check("wh_count", count, 8);
    do_lookup(16'h15);
    check("wh_hit", lkp_hit, 1);
    check("wh_idx", lkp_idx, 5);
    check("wh_val", lkp_val, 32'hFF);

    // Flush: busy for 8 cycles, count falls, lookups miss
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    check("fl_busy0", busy, 1);
    check("fl_count0", count, 8);
    lkp_vld = 1'b1; lkp_key = 16'h18;
    for (int k = 1; k < 8; k++) begin
      step();
      check("fl_busy", busy, 1);
      check("fl_count", count, 4'(8 - k));
      check("fl_lkp_hit", lkp_hit, 0);
    end
    step();
    lkp_vld = 1'b0;
    check("fl_done_busy", busy, 0);
    check("fl_done_count", count, 0);
    check("fl_done_hit", lkp_hit, 0);

    // Invalidate the age-1 key, reallocate its slot, then check LRU order via evictions
    for (int i = 0; i < 4; i++) do_write(16'h20 + 16'(i), 32'hB0 + 32'(i));
    check("inv_pre_count", count, 4);
    do_inv(16'h22);
    check("inv_count", count, 3);
    do_write(16'h24, 32'hB4);
    do_lookup(16'h24);
    check("inv_realloc_idx", lkp_idx, 2);
    check("inv_realloc_val", lkp_val, 32'hB4);
    for (int i = 5; i < 9; i++) begin
      do_write(16'h20 + 16'(i), 32'hB0 + 32'(i));
      check("inv_fill_evict", evict_vld, 0);
    end
    check("inv_full_count", count, 8);
    do_inv(16'h99);
    check("inv_miss_count", count, 8);
    do_write(16'h29, 32'hB9);
    check("lru1_vld", evict_vld, 1);
    check("lru1_key", evict_key, 16'h20);
    check("lru1_val", evict_val, 32'hB0);
    do_write(16'h2A, 32'hBA);
    check("lru2_vld", evict_vld, 1);
    check("lru2_key", evict_key, 16'h21);
    check("lru2_val", evict_val, 32'hB1);

    // Reset during the third flush cycle
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check("rstfl_busy", busy, 0);
    check("rstfl_count", count, 0);
    rst = 1'b0;
    step();
    check("rstfl_busy_after", busy, 0);
    check("rstfl_count_after", count, 0);

    // Statistics: 3 hits, 2 misses
    do_write(16'h30, 32'hC0);
    repeat (3) do_lookup(16'h30);
    check("st_last_hit", lkp_hit, 1);
    do_lookup(16'h31);
    do_lookup(16'h32);
    check("st_last_miss", lkp_hit, 0);
`ifdef CAM_LRU_STATS_EN
    check("st_hits", stat_hits, 3);
    check("st_misses", stat_misses, 2);
`else
    check("st_hits", stat_hits, 0);
    check("st_misses", stat_misses, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
